// File: rtl/pdp8_pkg.sv
// pdp8_pkg: definitions shared across the PDP-8 codebase slice.
//  - ic_state_t: interrupt_controller FSM encoding (also traced on the debug port).
//  - IOT_SKON / IOT_ION / IOT_IOF: the interrupt-control IOT opcodes.
package pdp8_pkg;

  typedef enum logic [1:0] {
    IC_DISABLED = 2'd0,
    IC_ARMING   = 2'd1,
    IC_ENABLED  = 2'd2,
    IC_TAKEN    = 2'd3
  } ic_state_t;

  localparam logic [11:0] IOT_SKON = 12'o6000;
  localparam logic [11:0] IOT_ION  = 12'o6001;
  localparam logic [11:0] IOT_IOF  = 12'o6002;

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: link between the CPU sequencer and the interrupt controller.
//  master (CPU side) drives:
//    instrDone, ckFetch, ionInstr, iofInstr, skonInstr
//  slave (controller side) drives:
//    irqOverride, irqAck, skip, ie, irqPending, state
interface interrupt_controller_if;
  import pdp8_pkg::*;

  logic      instrDone;
  logic      ckFetch;
  logic      ionInstr;
  logic      iofInstr;
  logic      skonInstr;
  logic      irqOverride;
  logic      irqAck;
  logic      skip;
  logic      ie;
  logic      irqPending;
  ic_state_t state;

  modport master (
    output instrDone, ckFetch, ionInstr, iofInstr, skonInstr,
    input  irqOverride, irqAck, skip, ie, irqPending, state
  );

  modport slave (
    input  instrDone, ckFetch, ionInstr, iofInstr, skonInstr,
    output irqOverride, irqAck, skip, ie, irqPending, state
  );

endinterface

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchroniser for a bus of level request lines.
//  Parameters: WIDTH (lines), STAGES (flops per line, >=2).
//  Ports:
//    clk    in  1      clock
//    reset  in  1      asynchronous active-low reset, clears all stages
//    d      in  WIDTH  asynchronous inputs
//    q      out WIDTH  synchronised outputs, STAGES cycles behind d
module irq_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: PDP-8 program-interrupt sequencer (feeds ProgramCounter / IR mux).
//  Parameters: NIRQ (request lines), SYNC_STAGES (synchroniser depth, >=2).
//  Ports:
//    clk       in   system clock
//    reset     in   asynchronous active-low reset
//    irqLines  in   NIRQ raw level requests, asynchronous to clk
//    maskLoad  in   (IRQ_MASK_EN only) load maskIn into the mask register
//    maskIn    in   (IRQ_MASK_EN only) NIRQ new mask value
//    bus       slave modport of interrupt_controller_if (boundary strobes, IOT
//              decodes in; irqOverride/irqAck/skip/ie/irqPending/state out)
//  Optional feature: macro IRQ_MASK_EN adds a per-line mask register (resets all-ones).
module interrupt_controller
  import pdp8_pkg::*;
#(
  parameter int unsigned NIRQ        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NIRQ-1:0]       irqLines,
`ifdef IRQ_MASK_EN
  input  logic                  maskLoad,
  input  logic [NIRQ-1:0]       maskIn,
`endif
  interrupt_controller_if.slave bus
);

  logic [NIRQ-1:0] irq_sync_q;
  logic            pending;
  ic_state_t       state, next_state;
  logic            ack_d, skip_d;
  logic            ack_q, skip_q;

  irq_sync #(
    .WIDTH  (NIRQ),
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irqLines),
    .q     (irq_sync_q)
  );

`ifdef IRQ_MASK_EN
  logic [NIRQ-1:0] mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        mask <= '1;
    else if (maskLoad) mask <= maskIn;
  end

  assign pending = |(irq_sync_q & mask);
`else
  assign pending = |irq_sync_q;
`endif

  // State register; ack/skip are registered so they pulse in the cycle after the boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IC_DISABLED;
      ack_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state  <= next_state;
      ack_q  <= ack_d;
      skip_q <= skip_d;
    end
  end

  // Next state: rules are evaluated in priority order, only at instruction boundaries.
  always_comb begin
    next_state = state;
    if (bus.instrDone) begin
      if (state == IC_TAKEN) begin
        next_state = IC_DISABLED;
      end else if (bus.iofInstr || bus.skonInstr) begin
        next_state = IC_DISABLED;
      end else if (bus.ionInstr) begin
        // ION while already ARMING/ENABLED leaves the state alone.
        if (state == IC_DISABLED) next_state = IC_ARMING;
      end else begin
        unique case (state)
          IC_ARMING:  next_state = IC_ENABLED;
          IC_ENABLED: if (pending) next_state = IC_TAKEN;
          default:    next_state = state;
        endcase
      end
    end
  end

  // Output decode.
  always_comb begin
    ack_d  = (state == IC_ENABLED) && (next_state == IC_TAKEN);
    skip_d = bus.instrDone && (state == IC_ENABLED) && !bus.iofInstr && bus.skonInstr;
  end

  // Override and ie decode straight from the state flops so reset removes them at once.
  assign bus.irqOverride = (state == IC_TAKEN);
  assign bus.ie          = (state == IC_ARMING) || (state == IC_ENABLED);
  assign bus.irqAck      = ack_q;
  assign bus.skip        = skip_q;
  assign bus.irqPending  = pending;
  assign bus.state       = state;

  // The fetch stage must never see the override appear in the middle of a fetch.
  a_no_override_rise_in_fetch: assert property (
    @(posedge clk) disable iff (!reset) !($rose(bus.irqOverride) && bus.ckFetch)
  );

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;
  import pdp8_pkg::*;

  localparam int NIRQ = 8;
  localparam int SYNC = 2;

  logic            clk;
  logic            reset;
  logic [NIRQ-1:0] irqLines;
`ifdef IRQ_MASK_EN
  logic            maskLoad;
  logic [NIRQ-1:0] maskIn;
`endif

  interrupt_controller_if bus();

  interrupt_controller #(
    .NIRQ        (NIRQ),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irqLines (irqLines),
`ifdef IRQ_MASK_EN
    .maskLoad (maskLoad),
    .maskIn   (maskIn),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: software-visible enable flag, a one-boundary ION delay,
  // an "interrupt being taken" flag and a history of sampled request lines.
  bit              m_ie, m_delay, m_taken, m_ack, m_skip, m_pend;
  logic [NIRQ-1:0] m_mask;
  logic [NIRQ-1:0] hist [SYNC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ie = 0; m_delay = 0; m_taken = 0; m_ack = 0; m_skip = 0; m_pend = 0;
    m_mask = '1;
    for (int i = 0; i < SYNC; i++) hist[i] = '0;
  endtask

  function automatic logic [1:0] m_state();
    if (m_taken) return 2'd3;
    if (m_ie)    return m_delay ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    m_ack  = 0;
    m_skip = 0;
    if (bus.instrDone) begin
      if (m_taken) begin
        m_taken = 0; m_ie = 0; m_delay = 0;
      end else if (bus.iofInstr) begin
        m_ie = 0; m_delay = 0;
      end else if (bus.skonInstr) begin
        m_skip = m_ie && !m_delay;
        m_ie = 0; m_delay = 0;
      end else if (bus.ionInstr) begin
        if (!m_ie) begin m_ie = 1; m_delay = 1; end
      end else if (m_delay) begin
        m_delay = 0;
      end else if (m_ie && m_pend) begin
        m_taken = 1; m_ie = 0; m_ack = 1;
      end
    end
`ifdef IRQ_MASK_EN
    if (maskLoad) m_mask = maskIn;
`endif
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = irqLines;
    m_pend = |(hist[SYNC-1] & m_mask);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(bus.state),       32'(m_state()));
    chk({tag, ".ie"},     32'(bus.ie),          32'(m_ie));
    chk({tag, ".ovr"},    32'(bus.irqOverride), 32'(m_taken));
    chk({tag, ".ack"},    32'(bus.irqAck),      32'(m_ack));
    chk({tag, ".skip"},   32'(bus.skip),        32'(m_skip));
    chk({tag, ".pend"},   32'(bus.irqPending),  32'(m_pend));
  endtask

  // One clock: drive at the falling edge, check 1ns after the rising edge.
  task automatic cyc(input string tag, input logic done, input logic ion, input logic iof,
                     input logic skon, input logic fetch, input logic [NIRQ-1:0] lines);
    bus.instrDone = done;
    bus.ionInstr  = ion;
    bus.iofInstr  = iof;
    bus.skonInstr = skon;
    bus.ckFetch   = fetch;
    irqLines      = lines;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  logic [11:0] opcodes [4];
  logic [NIRQ-1:0] rl;

  initial begin
    opcodes[0] = IOT_SKON; opcodes[1] = IOT_ION; opcodes[2] = IOT_IOF; opcodes[3] = 12'o7000;
    reset = 1'b0;
    irqLines = '0;
    bus.instrDone = 0; bus.ionInstr = 0; bus.iofInstr = 0; bus.skonInstr = 0; bus.ckFetch = 0;
`ifdef IRQ_MASK_EN
    maskLoad = 0; maskIn = '0;
`endif
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: request synchronises in two clocks; no override while disabled
    cyc("s1.sync1", 0, 0, 0, 0, 0, 8'h08);
    cyc("s1.sync2", 0, 0, 0, 0, 0, 8'h08);
    cyc("s1.bnd",   1, 0, 0, 0, 0, 8'h08);

    // 2: ION arms, next boundary enables, following boundary takes
    cyc("s2.ion",    1, 1, 0, 0, 0, 8'h08);
    cyc("s2.enable", 1, 0, 0, 0, 0, 8'h08);
    cyc("s2.take",   1, 0, 0, 0, 0, 8'h08);
    cyc("s2.after",  0, 0, 0, 0, 0, 8'h08);

    // 3: forced fetch, then the JMS boundary clears everything
    cyc("s3.fetch1", 0, 0, 0, 0, 1, 8'h08);
    cyc("s3.fetch2", 0, 0, 0, 0, 1, 8'h08);
    cyc("s3.jms",    1, 0, 0, 0, 0, 8'h00);
    cyc("s3.idle",   0, 0, 0, 0, 0, 8'h00);
    cyc("s3.idle2",  0, 0, 0, 0, 0, 8'h00);

    // 4: ION+IOF together in ENABLED -> IOF wins
    cyc("s4.ion",    1, 1, 0, 0, 0, 8'h00);
    cyc("s4.enable", 1, 0, 0, 0, 0, 8'h00);
    cyc("s4.ioniof", 1, 1, 1, 0, 0, 8'h00);
    cyc("s4.after",  0, 0, 0, 0, 0, 8'h00);

    // 5: SKON in ENABLED skips, SKON in DISABLED does not; ION no-op in ARMING
    cyc("s5.ion",     1, 1, 0, 0, 0, 8'h00);
    cyc("s5.ion2",    1, 1, 0, 0, 0, 8'h00);
    cyc("s5.enable",  1, 0, 0, 0, 0, 8'h00);
    cyc("s5.skon",    1, 0, 0, 1, 0, 8'h00);
    cyc("s5.after",   0, 0, 0, 0, 0, 8'h00);
    cyc("s5.skonoff", 1, 0, 0, 1, 0, 8'h00);

    // 6: reset during TAKEN drops override immediately, no ack afterwards
    cyc("s6.ion",    1, 1, 0, 0, 0, 8'h80);
    cyc("s6.enable", 1, 0, 0, 0, 0, 8'h80);
    cyc("s6.take",   1, 0, 0, 0, 0, 8'h80);
    bus.instrDone = 0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("s6.rst");
    #3;
    reset = 1'b1;
    cyc("s6.post", 0, 0, 0, 0, 0, 8'h00);

`ifdef IRQ_MASK_EN
    maskLoad = 1; maskIn = 8'h00;
    cyc("m.load", 0, 0, 0, 0, 0, 8'h00);
    maskLoad = 0;
    cyc("m.ff1", 0, 0, 0, 0, 0, 8'hFF);
    cyc("m.ff2", 0, 0, 0, 0, 0, 8'hFF);
    cyc("m.ff3", 0, 0, 0, 0, 0, 8'hFF);
    maskLoad = 1; maskIn = 8'h10;
    cyc("m.load2", 0, 0, 0, 0, 0, 8'hFF);
    maskLoad = 0;
`endif

    // Randomised phase: back-to-back boundaries, mixed IOTs, slowly varying requests.
    rl = '0;
    for (int n = 0; n < 400; n++) begin
      logic [11:0] op;
      logic        both;
      op   = opcodes[$urandom_range(0, 3)];
      both = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) rl = ($urandom_range(0, 1) != 0) ? NIRQ'($urandom) : '0;
`ifdef IRQ_MASK_EN
      maskLoad = ($urandom_range(0, 15) == 0);
      maskIn   = NIRQ'($urandom);
`endif
      cyc("rand", 1'($urandom_range(0, 1)), (op == IOT_ION) || both, (op == IOT_IOF) || both,
          (op == IOT_SKON), 1'b0, rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
